// File: rtl/booth_pp_encoder.sv
// -----------------------------------------------------------------------------
// booth_pp_encoder
//
// Radix-4 (modified Booth) partial-product generator for a 10x10 signed
// multiply. It produces five 13-bit rows plus a per-row +1 correction bit.
// Row i is weighted 2^(2i). The sum of all rows and correction bits equals a*b
// modulo 2^21.
//
// The block is a two-stage valid/ready pipeline:
//   S1 holds the multiplicand and the decoded Booth controls {neg, one, two}
//      for each digit.
//   S2 holds the finished rows and the correction bits.
//
// Optional feature (macro BOOTH_PP_ZERO_SKIP_EN):
//   When either operand is zero, the set leaves S2 as all-zero rows with no
//   correction bits. pp_zero is raised, aligned with that set.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair present
//   in_ready   out  operand pair accepted this cycle
//   a          in   [9:0]  multiplicand, signed
//   b          in   [9:0]  multiplier, signed
//   out_valid  out  partial-product set present
//   out_ready  in   consumer accepts the set this cycle
//   ops        out  [4:0][12:0] partial-product rows, row i weighted 2^(2i)
//   pp_neg     out  [4:0] +1 correction per row, weighted 2^(2i)
//   pp_zero    out  zero-operand flag (only with BOOTH_PP_ZERO_SKIP_EN)
// -----------------------------------------------------------------------------
module booth_pp_encoder (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       a,
    input  logic [9:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0][12:0] ops,
    output logic [4:0]       pp_neg
`ifdef BOOTH_PP_ZERO_SKIP_EN
    ,
    output logic             pp_zero
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high. A stage accepts new contents when it is empty, or when
    // its current contents leave on the same edge. Ready is combinational
    // back through both stages, so a full pipeline still moves one set per
    // cycle with out_ready held high.
    logic s1_adv;
    logic s2_adv;

    // ---------------- S1: Booth digit decode ----------------
    logic             s1_valid_q;
    logic [9:0]       s1_a_q;
    logic [4:0]       s1_neg_q, s1_one_q, s1_two_q;
    logic [4:0]       neg_d, one_d, two_d;
    logic [10:0]      b_ext;

    // Append b[-1] = 0, so digit i reads the triplet b_ext[2i+2 : 2i].
    assign b_ext = {b, 1'b0};

    always_comb begin
        neg_d = '0;
        one_d = '0;
        two_d = '0;
        for (int i = 0; i < 5; i++) begin
            // 111 is a zero digit, so neg is suppressed there. This keeps
            // both zero encodings free of a correction bit.
            neg_d[i] = b_ext[2*i+2] & ~(b_ext[2*i+1] & b_ext[2*i]);
            one_d[i] = b_ext[2*i+1] ^ b_ext[2*i];
            two_d[i] = ( b_ext[2*i+2] & ~b_ext[2*i+1] & ~b_ext[2*i]) |
                       (~b_ext[2*i+2] &  b_ext[2*i+1] &  b_ext[2*i]);
        end
    end

`ifdef BOOTH_PP_ZERO_SKIP_EN
    logic s1_zero_q;
    logic s2_zero_q;
`endif

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_neg_q   <= '0;
            s1_one_q   <= '0;
            s1_two_q   <= '0;
`ifdef BOOTH_PP_ZERO_SKIP_EN
            s1_zero_q  <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q    <= a;
                s1_neg_q  <= neg_d;
                s1_one_q  <= one_d;
                s1_two_q  <= two_d;
`ifdef BOOTH_PP_ZERO_SKIP_EN
                s1_zero_q <= (a == 10'd0) || (b == 10'd0);
`endif
            end
        end
    end

    // ---------------- S2: row formation ----------------
    logic             s2_valid_q;
    logic [4:0][12:0] ops_q, ops_d;
    logic [4:0]       pp_neg_q, pp_neg_d;
    logic [4:0][10:0] mag_w;
    logic [4:0][10:0] row_w;

    always_comb begin
        mag_w    = '0;
        row_w    = '0;
        ops_d    = '0;
        pp_neg_d = '0;
        for (int i = 0; i < 5; i++) begin
            // |d|*a at 11 bits: 2a always fits, even for a = -512.
            if (s1_one_q[i]) begin
                mag_w[i] = {s1_a_q[9], s1_a_q};
            end else if (s1_two_q[i]) begin
                mag_w[i] = {s1_a_q, 1'b0};
            end
            // A negative row is ~m. The missing +1 travels in pp_neg.
            row_w[i]    = s1_neg_q[i] ? ~mag_w[i] : mag_w[i];
            ops_d[i]    = {{2{row_w[i][10]}}, row_w[i]};
            pp_neg_d[i] = s1_neg_q[i];
        end
`ifdef BOOTH_PP_ZERO_SKIP_EN
        if (s1_zero_q) begin
            ops_d    = '0;
            pp_neg_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            ops_q      <= '0;
            pp_neg_q   <= '0;
`ifdef BOOTH_PP_ZERO_SKIP_EN
            s2_zero_q  <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                ops_q     <= ops_d;
                pp_neg_q  <= pp_neg_d;
`ifdef BOOTH_PP_ZERO_SKIP_EN
                s2_zero_q <= s1_zero_q;
`endif
            end
        end
    end

    // The data registers load only on a transfer, so stale contents stay
    // there after a set leaves. They are masked to zero while no set is valid.
    assign out_valid = s2_valid_q;
    assign ops       = s2_valid_q ? ops_q    : '0;
    assign pp_neg    = s2_valid_q ? pp_neg_q : '0;
`ifdef BOOTH_PP_ZERO_SKIP_EN
    assign pp_zero   = s2_valid_q & s2_zero_q;
`endif

endmodule

// File: tb/tb_booth_pp_encoder.sv
// -----------------------------------------------------------------------------
// tb_booth_pp_encoder
//
// Self-checking bench for booth_pp_encoder.
//
// The reference model recomputes each Booth digit as -2*b[2i+1] + b[2i] +
// b[2i-1]. It then forms every row as digit*a, minus one when the digit is
// negative. A scoreboard queue keeps the order of accepted operand pairs, and
// every emitted set is checked against the model and against the sum
// invariant.
// -----------------------------------------------------------------------------
module tb_booth_pp_encoder;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       a;
    logic [9:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [4:0][12:0] ops;
    logic [4:0]       pp_neg;
`ifdef BOOTH_PP_ZERO_SKIP_EN
    logic             pp_zero;
`endif

    always #5 clk = ~clk;

    booth_pp_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ops       (ops),
        .pp_neg    (pp_neg)
`ifdef BOOTH_PP_ZERO_SKIP_EN
        ,
        .pp_zero   (pp_zero)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model(input logic [9:0] ma, input logic [9:0] mb,
                                  output logic [4:0][12:0] mops,
                                  output logic [4:0] mneg, output logic mzero);
        int ai, d, row, bit_hi, bit_mid, bit_lo;
        ai    = int'($signed(ma));
        mops  = '0;
        mneg  = '0;
        mzero = (ma == 10'd0) || (mb == 10'd0);
        for (int i = 0; i < 5; i++) begin
            bit_hi  = int'(mb[2*i+1]);
            bit_mid = int'(mb[2*i]);
            bit_lo  = (i == 0) ? 0 : int'(mb[2*i-1]);
            d   = -2 * bit_hi + bit_mid + bit_lo;
            row = d * ai;
            if (d < 0) begin
                row     = row - 1;
                mneg[i] = 1'b1;
            end
            mops[i] = 13'(row);
        end
`ifdef BOOTH_PP_ZERO_SKIP_EN
        if (mzero) begin
            mops = '0;
            mneg = '0;
        end
`else
        mzero = 1'b0;
`endif
    endfunction

    function automatic logic [20:0] inv_sum(input logic [4:0][12:0] s_ops, input logic [4:0] s_neg);
        int s;
        logic [31:0] sv;
        s = 0;
        for (int i = 0; i < 5; i++)
            s += int'($signed(s_ops[i])) * (1 << (2*i)) + int'(s_neg[i]) * (1 << (2*i));
        sv = 32'(s);
        return sv[20:0];
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [19:0]      exp_q[$];
    logic             stall_prev = 1'b0;
    logic [4:0][12:0] prev_ops;
    logic [4:0]       prev_neg;

    always @(negedge clk) begin
        logic [19:0]      item;
        logic [4:0][12:0] e_ops;
        logic [4:0]       e_neg;
        logic             e_zero;
        logic [31:0]      prod;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (!out_valid) begin
                if (ops != '0 || pp_neg != '0)
                    check("idle_outputs_zero", {ops, pp_neg}, '0);
            end
            if (stall_prev) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_ops_hold", ops, prev_ops);
                check("stall_neg_hold", pp_neg, prev_neg);
            end
            stall_prev = out_valid & ~out_ready;
            prev_ops   = ops;
            prev_neg   = pp_neg;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    item = exp_q.pop_front();
                    model(item[19:10], item[9:0], e_ops, e_neg, e_zero);
                    check("sb_ops", ops, e_ops);
                    check("sb_pp_neg", pp_neg, e_neg);
`ifdef BOOTH_PP_ZERO_SKIP_EN
                    check("sb_pp_zero", pp_zero, e_zero);
`endif
                    prod = 32'(int'($signed(item[19:10])) * int'($signed(item[9:0])));
                    check("sb_invariant", inv_sum(ops, pp_neg), prod[20:0]);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({a, b});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic random_soak(input int n);
        int  sent = 0;
        int  cyc  = 0;
        bit  xfer = 1'b1;
        in_valid = 1'b0;
        while (sent < n && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            if (!in_valid || xfer) begin
                a = 10'($urandom);
                b = 10'($urandom);
                if ($urandom_range(0, 15) == 0) a = 10'd0;
                if ($urandom_range(0, 15) == 0) b = 10'd0;
                if ($urandom_range(0, 15) == 0) a = 10'h200;
                if ($urandom_range(0, 15) == 0) b = 10'h3FF;
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            xfer = in_valid & in_ready;
            if (xfer) sent++;
        end
        check("soak_all_sent", sent, n);
        @(posedge clk); #1;
        drain();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [9:0]       a;
        logic [9:0]       b;
        logic [4:0][12:0] ops;
        logic [4:0]       neg;
        logic             zero;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat;
        int          accepts;
        int          idx;
        int          stale;
        bit          xfer;
        logic [9:0]  bp_a[4];
        logic [9:0]  bp_b[4];

        vecs[0] = '{a:10'd3,    b:10'd5,    ops:{13'h0, 13'h0, 13'h0, 13'h3, 13'h3},       neg:5'b00000, zero:1'b0};
        vecs[1] = '{a:10'h200,  b:10'h200,  ops:{13'h03FF, 13'h0, 13'h0, 13'h0, 13'h0},   neg:5'b10000, zero:1'b0};
        vecs[2] = '{a:10'd1,    b:10'h3FF,  ops:{13'h0, 13'h0, 13'h0, 13'h0, 13'h1FFE},   neg:5'b00001, zero:1'b0};
        vecs[3] = '{a:10'h1FF,  b:10'h1FF,  ops:{13'h03FE, 13'h0, 13'h0, 13'h0, 13'h1E00}, neg:5'b00001, zero:1'b0};
        vecs[4] = '{a:10'h3FF,  b:10'd2,    ops:{13'h0, 13'h0, 13'h0, 13'h1FFF, 13'h0001}, neg:5'b00001, zero:1'b0};
`ifdef BOOTH_PP_ZERO_SKIP_EN
        vecs[5] = '{a:10'd0,    b:10'h3FF,  ops:'0,                                        neg:5'b00000, zero:1'b1};
`else
        vecs[5] = '{a:10'd0,    b:10'h3FF,  ops:{13'h0, 13'h0, 13'h0, 13'h0, 13'h1FFF},   neg:5'b00001, zero:1'b0};
`endif

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_ops", ops, '0);
        check("reset_pp_neg", pp_neg, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("in_ready_after_reset", in_ready, 1'b1);

        // Table: one set at a time, latency and exact rows
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            a        = vecs[v].a;
            b        = vecs[v].b;
            in_valid = 1'b1;
            lat      = 0;
            do begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                lat++;
            end while (!out_valid && lat < 10);
            check("vec_latency", lat, 2);
            check("vec_ops", ops, vecs[v].ops);
            check("vec_pp_neg", pp_neg, vecs[v].neg);
`ifdef BOOTH_PP_ZERO_SKIP_EN
            check("vec_pp_zero", pp_zero, vecs[v].zero);
`endif
        end
        drain();

        // Backpressure: 4 back-to-back sets, 5 stalled cycles, then release
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 10'($urandom);
            bp_b[i] = 10'($urandom);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx       = 0;
        accepts   = 0;
        in_valid  = 1'b1;
        a         = bp_a[0];
        b         = bp_b[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            xfer = in_valid & in_ready;
            if (xfer) accepts++;
            @(posedge clk); #1;
            if (xfer) begin
                idx++;
                if (idx < 4) begin
                    a = bp_a[idx];
                    b = bp_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp_accepts_while_stalled", accepts, 2);
        check("bp_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_no_gap", out_valid, 1'b1);
            xfer = in_valid & in_ready;
            @(posedge clk); #1;
            if (xfer) begin
                idx++;
                if (idx < 4) begin
                    a = bp_a[idx];
                    b = bp_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp_all_accepted", idx, 4);
        drain();

        // Reset while two sets are in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 10'd7;  b = 10'd9;
        @(posedge clk); #1;
        a = 10'd11; b = 10'h3F0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midflight_out_valid_set", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midflight_async_clear", out_valid, 1'b0);
        check("midflight_ops_clear", ops, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("midflight_in_ready", in_ready, 1'b1);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midflight_no_stale", stale, 0);

        // Random soak
        random_soak(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
